// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: bus register map,
// controller state encoding and STATUS register field layout.
package intr_pkg;

  localparam int unsigned BUS_DATA_W = 32;
  localparam int unsigned BUS_ADDR_W = 2;

  // Word register map on the CPU bus slave port
  localparam logic [BUS_ADDR_W-1:0] INTR_MASK  = 2'd0;
  localparam logic [BUS_ADDR_W-1:0] INTR_PEND  = 2'd1;
  localparam logic [BUS_ADDR_W-1:0] INTR_STAT  = 2'd2;
  localparam logic [BUS_ADDR_W-1:0] INTR_FORCE = 2'd3;

  // Handshake state; 2'b11 is never entered and recovers to idle
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } intr_state_e;

  // STATUS layout: [1:0] state, [12:8] in-service index+1
  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_STATE_W   = 2;
  localparam int unsigned STAT_IDX_LSB   = 8;
  localparam int unsigned STAT_IDX_W     = 5;

endpackage

// File: rtl/intr_ctrl_n_prio_enc.sv
// Lowest-index-first priority encoder (purely combinational).
// Ports:
//   vec_i     request vector
//   onehot_c  one-hot of the lowest set bit, zero when none
//   idx_c     index+1 of the lowest set bit, zero when none
//   valid_c   any bit set
module prio_enc_n #(
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 5
) (
  input  logic [N-1:0]     vec_i,
  output logic [N-1:0]     onehot_c,
  output logic [IDX_W-1:0] idx_c,
  output logic             valid_c
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    onehot_c = '0;
    idx_c    = '0;
    valid_c  = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        onehot_c    = '0;
        onehot_c[i] = 1'b1;
        idx_c       = IDX_W'(i + 1);
        valid_c     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/intr_ctrl_n.sv
// Interrupt controller: per-channel edge/level pending capture, bus
// programmable mask, fixed lowest-index priority and a frozen-grant
// request / acknowledge / return handshake with the CPU.
// Ports:
//   clk, reset        clock, synchronous active-low reset
//   irq_i             raw interrupt lines (synchronous to clk)
//   int_en_i          CPU global interrupt enable
//   Ireq / Iack       request to CPU / acknowledge from CPU
//   eret_i            return-from-handler pulse
//   gntInt, cause_o   granted channel one-hot and index+1
//   stb_i, we_i, addr_i, data_i, data_o, ack_o   bus slave port
module intr_ctrl_n
  import intr_pkg::*;
#(
  parameter int unsigned        NUM_IRQ   = 8,
  parameter int unsigned        CAUSE_W   = 5,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b1}}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic                  int_en_i,
  output logic                  Ireq,
  input  logic                  Iack,
  input  logic                  eret_i,
  output logic [NUM_IRQ-1:0]    gntInt,
  output logic [CAUSE_W-1:0]    cause_o,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [BUS_ADDR_W-1:0] addr_i,
  input  logic [BUS_DATA_W-1:0] data_i,
  output logic [BUS_DATA_W-1:0] data_o,
  output logic                  ack_o
);

  intr_state_e           state_q, state_d;
  logic [NUM_IRQ-1:0]    mask_q, mask_d;
  logic [NUM_IRQ-1:0]    pend_q, pend_d;
  logic [NUM_IRQ-1:0]    prev_q, prev_d;
  logic                  ireq_q, ireq_d;
  logic [NUM_IRQ-1:0]    gnt_q, gnt_d;
  logic [CAUSE_W-1:0]    cause_q, cause_d;
  logic                  ack_q, ack_d;
  logic [BUS_DATA_W-1:0] data_q, data_d;

  logic                  bus_wr, bus_rd;
  logic [NUM_IRQ-1:0]    wr_bits;
  logic [NUM_IRQ-1:0]    pend_set, pend_clr, edge_next;
  logic [NUM_IRQ-1:0]    active;
  logic [NUM_IRQ-1:0]    act_onehot;
  logic [CAUSE_W-1:0]    act_idx;
  logic                  act_valid;
  logic [BUS_DATA_W-1:0] rd_data;
  logic                  unused_data_hi;

  assign bus_wr  = stb_i & we_i;
  assign bus_rd  = stb_i & ~we_i;
  assign wr_bits = data_i[NUM_IRQ-1:0];
  // Upper write-data bits have no backing register
  assign unused_data_hi = ^data_i[BUS_DATA_W-1:NUM_IRQ];

  assign active = pend_q & mask_q;

  prio_enc_n #(
    .N     (NUM_IRQ),
    .IDX_W (CAUSE_W)
  ) u_prio (
    .vec_i    (active),
    .onehot_c (act_onehot),
    .idx_c    (act_idx),
    .valid_c  (act_valid)
  );

  // Pending capture: edge channels are sticky with set winning over clear,
  // level channels simply follow the line one cycle late
  always_comb begin
    prev_d   = irq_i;
    mask_d   = mask_q;
    pend_set = irq_i & ~prev_q;
    pend_clr = '0;
    if (bus_wr && addr_i == INTR_MASK) begin
      mask_d = wr_bits;
    end
    if (bus_wr && addr_i == INTR_FORCE) begin
      pend_set = pend_set | wr_bits;
    end
    if (bus_wr && addr_i == INTR_PEND) begin
      pend_clr = wr_bits;
    end
    if (state_q == ST_REQ && Iack) begin
      pend_clr = pend_clr | gnt_q;
    end
    edge_next = (pend_q & ~pend_clr) | pend_set;
    pend_d    = (edge_next & EDGE_MASK) | (irq_i & ~EDGE_MASK);
  end

  // Handshake FSM; the grant is captured on REQ entry and held until idle
  always_comb begin
    state_d = state_q;
    ireq_d  = ireq_q;
    gnt_d   = gnt_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (int_en_i && act_valid) begin
          state_d = ST_REQ;
          ireq_d  = 1'b1;
          gnt_d   = act_onehot;
          cause_d = act_idx;
        end
      end
      ST_REQ: begin
        if (Iack) begin
          state_d = ST_SERVICE;
          ireq_d  = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (eret_i) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cause_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ireq_d  = 1'b0;
        gnt_d   = '0;
        cause_d = '0;
      end
    endcase
  end

  // Bus read mux and registered response
  always_comb begin
    rd_data = '0;
    case (addr_i)
      INTR_MASK: rd_data[NUM_IRQ-1:0] = mask_q;
      INTR_PEND: rd_data[NUM_IRQ-1:0] = pend_q;
      INTR_STAT: begin
        rd_data[STAT_STATE_LSB +: STAT_STATE_W] = state_q;
        rd_data[STAT_IDX_LSB +: STAT_IDX_W]     = STAT_IDX_W'(cause_q);
      end
      default:   rd_data = '0;
    endcase
    ack_d  = stb_i;
    data_d = bus_rd ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      ireq_q  <= 1'b0;
      gnt_q   <= '0;
      cause_q <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      prev_q  <= prev_d;
      ireq_q  <= ireq_d;
      gnt_q   <= gnt_d;
      cause_q <= cause_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  assign Ireq    = ireq_q;
  assign gntInt  = gnt_q;
  assign cause_o = cause_q;
  assign ack_o   = ack_q;
  assign data_o  = data_q;

endmodule

// File: tb/tb_intr_ctrl_n.sv
// Testbench for intr_ctrl_n: directed scenarios with literal expectations,
// then randomized traffic, all outputs compared every cycle to a
// behavioural model (channel 0 level triggered, the rest edge triggered).
module tb_intr_ctrl_n;
  import intr_pkg::*;

  localparam int unsigned N   = 8;
  localparam int unsigned CW  = 5;
  localparam logic [N-1:0] EDGE = 8'hFE;

  logic          clk;
  logic          reset;
  logic [N-1:0]  irq;
  logic          int_en;
  logic          ireq;
  logic          iack;
  logic          eret;
  logic [N-1:0]  gnt;
  logic [CW-1:0] cause;
  logic          stb;
  logic          we;
  logic [1:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  // Behavioural model state: registers as bit vectors, state as an integer,
  // granted channel as an index (-1 when none)
  int       m_state = 0;
  int       m_gidx  = -1;
  bit [7:0] m_mask  = '0;
  bit [7:0] m_pend  = '0;
  bit [7:0] m_prev  = '0;
  bit       m_ack   = 1'b0;
  bit [31:0] m_data = '0;

  intr_ctrl_n #(
    .NUM_IRQ   (N),
    .CAUSE_W   (CW),
    .EDGE_MASK (EDGE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_i    (irq),
    .int_en_i (int_en),
    .Ireq     (ireq),
    .Iack     (iack),
    .eret_i   (eret),
    .gntInt   (gnt),
    .cause_o  (cause),
    .stb_i    (stb),
    .we_i     (we),
    .addr_i   (addr),
    .data_i   (wdata),
    .data_o   (rdata),
    .ack_o    (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock edge of the model, evaluated with the inputs seen at that edge
  task automatic model_step();
    bit [7:0] np;
    bit [7:0] nm;
    int       first;
    bit       set_b;
    bit       clr_b;
    bit       wr;
    if (!reset) begin
      m_state = 0; m_gidx = -1; m_mask = '0; m_pend = '0; m_prev = '0;
      m_ack = 1'b0; m_data = '0;
    end else begin
      wr     = stb && we;
      m_ack  = stb;
      m_data = '0;
      if (stb && !we) begin
        case (addr)
          2'd0:    m_data = 32'(m_mask);
          2'd1:    m_data = 32'(m_pend);
          2'd2:    m_data = 32'(m_state) | (32'(m_gidx + 1) << 8);
          default: m_data = '0;
        endcase
      end
      first = -1;
      for (int i = 0; i < 8; i++)
        if (first < 0 && m_pend[i] && m_mask[i]) first = i;
      for (int i = 0; i < 8; i++) begin
        if (EDGE[i]) begin
          set_b = (irq[i] && !m_prev[i]) || (wr && addr == 2'd3 && wdata[i]);
          clr_b = (wr && addr == 2'd1 && wdata[i]) || (m_state == 1 && iack && m_gidx == i);
          np[i] = set_b ? 1'b1 : (clr_b ? 1'b0 : m_pend[i]);
        end else begin
          np[i] = irq[i];
        end
      end
      nm = m_mask;
      if (wr && addr == 2'd0) nm = wdata[7:0];
      case (m_state)
        0: if (int_en && first >= 0) begin m_state = 1; m_gidx = first; end
        1: if (iack) m_state = 2;
        2: if (eret) begin m_state = 0; m_gidx = -1; end
        default: m_state = 0;
      endcase
      m_pend = np;
      m_mask = nm;
      m_prev = irq;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    stb = 1'b1; we = 1'b1; addr = a; wdata = d;
    cyc();
    chk("wr_ack", 32'(ack), 32'd1);
    stb = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    stb = 1'b1; we = 1'b0; addr = a;
    cyc();
    chk("rd_ack", 32'(ack), 32'd1);
    chk(name, rdata, exp);
    stb = 1'b0;
  endtask

  task automatic pulse_iack();
    iack = 1'b1; cyc(); iack = 1'b0;
  endtask

  task automatic pulse_eret();
    eret = 1'b1; cyc(); eret = 1'b0;
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (started) begin
      chk("m_ireq",  32'(ireq),  32'(m_state == 1));
      chk("m_gnt",   32'(gnt),   (m_gidx < 0) ? 32'd0 : (32'd1 << m_gidx));
      chk("m_cause", 32'(cause), 32'(m_gidx + 1));
      chk("m_ack",   32'(ack),   32'(m_ack));
      chk("m_data",  rdata,      m_data);
    end
  end

  initial begin
    reset = 1'b0; irq = '0; int_en = 1'b0; iack = 1'b0; eret = 1'b0;
    stb = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    cyc(); cyc();
    started = 1'b1;
    chk("rst_ireq",  32'(ireq),  32'd0);
    chk("rst_gnt",   32'(gnt),   32'd0);
    chk("rst_cause", 32'(cause), 32'd0);
    chk("rst_ack",   32'(ack),   32'd0);
    chk("rst_data",  rdata,      32'd0);
    reset = 1'b1;

    // Edge trigger and priority
    bus_wr(INTR_MASK, 32'hFF);
    int_en = 1'b1;
    irq = 8'h24; cyc(); irq = '0; cyc();
    chk("prio_ireq",  32'(ireq),  32'd1);
    chk("prio_gnt",   32'(gnt),   32'h04);
    chk("prio_cause", 32'(cause), 32'd3);
    pulse_iack();
    chk("iack_ireq", 32'(ireq), 32'd0);
    bus_rd("prio_pend", INTR_PEND, 32'h20);
    pulse_eret();
    chk("eret_gnt", 32'(gnt), 32'd0);
    cyc();
    chk("second_gnt",   32'(gnt),   32'h20);
    chk("second_cause", 32'(cause), 32'd6);
    pulse_iack(); pulse_eret();

    // Frozen grant while a higher-priority line arrives
    irq = 8'h08; cyc(); irq = '0; cyc();
    chk("frz_gnt0", 32'(gnt), 32'h08);
    irq = 8'h01; cyc();
    chk("frz_gnt1", 32'(gnt),  32'h08);
    chk("frz_ireq", 32'(ireq), 32'd1);
    pulse_iack();
    chk("frz_gnt2", 32'(gnt), 32'h08);
    bus_rd("frz_stat", INTR_STAT, 32'h402);
    pulse_eret();
    chk("frz_gnt3", 32'(gnt), 32'd0);
    cyc();
    chk("ch0_ireq",  32'(ireq),  32'd1);
    chk("ch0_gnt",   32'(gnt),   32'h01);
    chk("ch0_cause", 32'(cause), 32'd1);

    // Level channel re-requests while held, then follows the line
    pulse_iack(); pulse_eret(); cyc();
    chk("lvl_ireq",  32'(ireq),  32'd1);
    chk("lvl_cause", 32'(cause), 32'd1);
    irq = '0; pulse_iack();
    bus_rd("lvl_pend", INTR_PEND, 32'h00);
    pulse_eret();

    // Set/clear collision: the rising edge wins
    int_en = 1'b0;
    irq = 8'h10; stb = 1'b1; we = 1'b1; addr = INTR_PEND; wdata = 32'h10;
    cyc();
    stb = 1'b0; we = 1'b0; irq = '0;
    bus_rd("coll_pend", INTR_PEND, 32'h10);
    bus_wr(INTR_PEND, 32'h10);
    bus_rd("coll_clr", INTR_PEND, 32'h00);

    // Bus, FORCE and mask
    int_en = 1'b1;
    bus_wr(INTR_MASK, 32'h00);
    bus_wr(INTR_FORCE, 32'h02);
    chk("mask_noreq0", 32'(ireq), 32'd0);
    cyc();
    chk("ack_drop", 32'(ack), 32'd0);
    bus_rd("force_pend", INTR_PEND, 32'h02);
    chk("mask_noreq1", 32'(ireq), 32'd0);
    bus_wr(INTR_MASK, 32'h02);
    cyc();
    chk("unmask_ireq",  32'(ireq),  32'd1);
    chk("unmask_cause", 32'(cause), 32'd2);

    // Reset in the middle of a request
    reset = 1'b0; cyc();
    chk("mid_ireq",  32'(ireq),  32'd0);
    chk("mid_gnt",   32'(gnt),   32'd0);
    chk("mid_cause", 32'(cause), 32'd0);
    chk("mid_ack",   32'(ack),   32'd0);
    reset = 1'b1;
    bus_rd("mid_mask", INTR_MASK, 32'h00);
    bus_rd("mid_stat", INTR_STAT, 32'h00);

    // Randomized traffic, checked only by the model comparison
    for (int k = 0; k < 4000; k++) begin
      reset  = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      int_en = ($urandom_range(0, 9) != 0);
      iack   = ($urandom_range(0, 2) == 0);
      eret   = ($urandom_range(0, 3) == 0);
      stb    = ($urandom_range(0, 2) == 0);
      we     = 1'($urandom);
      addr   = 2'($urandom);
      wdata  = $urandom;
      cyc();
    end
    reset = 1'b1; stb = 1'b0; iack = 1'b0; eret = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/intr_ctrl_n.md
# intr_ctrl_n

Parametrised interrupt controller between the peripheral interrupt lines and the multi-cycle CPU core. It generalises the CPU's fixed 4-line grant latch to `NUM_IRQ` channels with per-channel edge/level triggering, a bus-programmable mask, fixed priority, and a full request/acknowledge/return handshake. It supplies the one-hot grant and the encoded cause that the CPU folds into its Cause register. A word-wide slave port on the wishbone-style CPU bus exposes its registers.

## Interface
- `NUM_IRQ`, 8, number of interrupt channels, range 2..31.
- `CAUSE_W`, 5, width of `cause_o`; must be at least clog2(`NUM_IRQ`+1).
- `EDGE_MASK`, {NUM_IRQ{1'b1}}, per channel: 1 = rising-edge triggered, 0 = level triggered.
- `clk  in  1  system clock; all logic on posedge`
- `reset  in  1  synchronous, active-low reset`
- `irq_i  in  NUM_IRQ  raw interrupt lines, already synchronous to clk`
- `int_en_i  in  1  CPU global interrupt enable`
- `Ireq  out  1  interrupt request to CPU`
- `Iack  in  1  CPU acknowledge; sampled only in state REQ`
- `eret_i  in  1  one-cycle pulse from CPU on return from handler`
- `gntInt  out  NUM_IRQ  one-hot granted channel; zero when none`
- `cause_o  out  CAUSE_W  granted index+1; 0 = none`
- `stb_i  in  1  bus strobe, single-cycle`
- `we_i  in  1  bus write`
- `addr_i  in  2  word register select`
- `data_i  in  32  bus write data`
- `data_o  out  32  bus read data, valid with ack_o`
- `ack_o  out  1  bus acknowledge`

## Operation
- Registers: 0 MASK (rw, bit = enable); 1 PENDING (read; write-1-clears edge bits); 2 STATUS (ro: [1:0] state, [12:8] in-service index+1); 3 FORCE (wo: write-1 sets pending on edge channels). Bits above `NUM_IRQ` read 0 and ignore writes.
- Edge channel pending: set on 0->1 of `irq_i` (one previous-value register per channel) or FORCE write. Cleared by PENDING write-1, or by `Iack` on the granted channel. A set in the same cycle as a clear wins.
- Level channel pending: equals `irq_i`; PENDING and FORCE writes have no effect.
- Active vector = pending & MASK. Priority: lowest index wins.
- FSM:
  - IDLE -> REQ when `int_en_i` and active vector is non-zero. On entry, latch the grant snapshot into `gntInt`/`cause_o`.
  - REQ -> SERVICE when `Iack`=1.
  - SERVICE -> IDLE on `eret_i`. `gntInt`/`cause_o` clear on that transition.
  - Encoding 2'b00/01/10; 2'b11 is unreachable and returns to IDLE.
- Grant snapshot is frozen from REQ entry until IDLE:
  - Higher-priority arrivals wait.
  - A level line dropping during REQ does not withdraw `Ireq`; the grant completes with the latched cause.
  - Clearing `int_en_i` during REQ does not withdraw `Ireq`.
- No nesting. `Iack` outside REQ and `eret_i` outside SERVICE are ignored.

## Timing
- Reset (`reset`=0 at a clock edge): state IDLE; MASK, pending, and edge history = 0. `Ireq`, `gntInt`, `cause_o`, `ack_o`, `data_o` = 0.
- Reset asserted mid-handshake aborts immediately. Outputs are 0 at the next edge; the CPU must re-sync.
- Interrupt latency:
  - Edge on `irq_i` sampled at edge t.
  - Pending visible after t.
  - `Ireq`, `gntInt`, `cause_o` high after edge t+1: 2 cycles from input to request.
- `Iack` sampled high at edge t:
  - State SERVICE after t.
  - `Ireq` low after t.
  - Granted edge pending cleared at t.
- `eret_i` at edge t in SERVICE: IDLE after t. A new `Ireq` can rise after t+1.
- Bus: `stb_i` at edge t gives `ack_o` = 1 for exactly the cycle after t, with `data_o` valid. Writes take effect at edge t. Back-to-back strobes are accepted every cycle.
- A MASK write at edge t affects the active vector from cycle t+1. Clearing a mask bit never withdraws an in-flight grant.

## Structure
- Package `intr_pkg` holds:
  - register address localparams `INTR_MASK`, `INTR_PEND`, `INTR_STAT`, `INTR_FORCE`;
  - state typedef/encoding `ST_IDLE`, `ST_REQ`, `ST_SERVICE`;
  - STATUS field offsets.
- Sub-module `prio_enc_n` (parameter `N`): combinational lowest-index-first encoder producing one-hot, index+1, and valid. Instantiate it once.

## Test plan
- Edge trigger and priority: MASK=0xFF, `int_en_i`=1; pulse `irq_i`[5] and [2] in the same cycle. Expected: two cycles later `Ireq`=1, `gntInt`=0x04, `cause_o`=3. After `Iack`, PENDING reads 0x20.
- Frozen grant: during REQ for ch 3, raise ch 0. Expected: `gntInt` stays 0x08 through `Iack`/`eret_i`. Ch 0 requests 2 cycles after `eret_i`.
- Level channel with `EDGE_MASK`=0xFE: hold `irq_i`[0]=1, then `Iack`, `eret_i`. Expected: re-request with `cause_o`=1. Drop the line, then PENDING bit 0 = 0 the next cycle.
- Set/clear collision: write PENDING=0x10 in the same cycle as an `irq_i`[4] rising edge. Expected: PENDING bit 4 = 1.
- Bus and mask: write MASK=0x00, then FORCE=0x02. Expected: no `Ireq`; PENDING reads 0x02; `ack_o` high one cycle after each `stb_i`. Then MASK=0x02 gives `Ireq` one cycle after the write edge.
- Reset mid-REQ: drop `reset` while `Ireq`=1. Expected: at the next edge all outputs 0, MASK reads 0, state IDLE.
